// File: rtl/div_result_pipe.sv
// div_result_pipe: two-stage registered sign-fixup and exception stage behind the divider.
// Stage A captures the raw divider bundle. Stage B holds the corrected result and drives out_*.
// Saturating counters track delivered divide-by-zero and overflow results.
module div_result_pipe #(
    parameter int unsigned M     = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [M-1:0]     in_dividend,
    input  logic [M-1:0]     in_divisor,
    input  logic [M-1:0]     in_quot_mag,
    input  logic [M-1:0]     in_rem_mag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [M-1:0]     out_quotient,
    output logic [M-1:0]     out_remainder,
    output logic             out_dz,
    output logic             out_ov,
    output logic [CNT_W-1:0] dz_count,
    output logic [CNT_W-1:0] ov_count
);

    localparam logic [M-1:0]     MIN_VAL = {1'b1, {(M-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic         a_valid;
    logic [M-1:0] a_dividend;
    logic [M-1:0] a_divisor;
    logic [M-1:0] a_quot_mag;
    logic [M-1:0] a_rem_mag;
    logic         b_valid;

    logic         b_adv;
    logic         a_adv;
    logic         take;
    logic         deliver;

    logic [M-1:0] fix_q;
    logic [M-1:0] fix_r;
    logic         fix_dz;
    logic         fix_ov;

    // Handshake: B frees when empty or drained; A frees when it moves into B.
    assign b_adv     = !b_valid || out_ready;
    assign a_adv     = a_valid && b_adv;
    assign in_ready  = !a_valid || b_adv;
    assign take      = in_valid && in_ready;
    assign deliver   = b_valid && out_ready;
    assign out_valid = b_valid;

    // Exception substitution and sign correction of the stage A bundle.
    always_comb begin
        fix_dz = 1'b0;
        fix_ov = 1'b0;
        fix_q  = a_quot_mag;
        fix_r  = a_rem_mag;
        if (a_divisor == '0) begin
            fix_dz = 1'b1;
            fix_q  = '1;
            fix_r  = a_dividend;
        end else if ((a_dividend == MIN_VAL) && (a_divisor == '1)) begin
            fix_ov = 1'b1;
            fix_q  = MIN_VAL;
            fix_r  = '0;
        end else begin
            if (a_dividend[M-1] ^ a_divisor[M-1]) begin
                fix_q = -a_quot_mag;
            end
            if (a_dividend[M-1]) begin
                fix_r = -a_rem_mag;
            end
        end
    end

    // Stage A: capture raw bundle; empties when it moves on with nothing new arriving.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid <= 1'b0;
        end else if (take) begin
            a_valid <= 1'b1;
        end else if (a_adv) begin
            a_valid <= 1'b0;
        end
        if (take) begin
            a_dividend <= in_dividend;
            a_divisor  <= in_divisor;
            a_quot_mag <= in_quot_mag;
            a_rem_mag  <= in_rem_mag;
        end
    end

    // Stage B: corrected result register, held while stalled downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_valid       <= 1'b0;
            out_quotient  <= '0;
            out_remainder <= '0;
            out_dz        <= 1'b0;
            out_ov        <= 1'b0;
        end else if (b_adv) begin
            b_valid <= a_valid;
            if (a_valid) begin
                out_quotient  <= fix_q;
                out_remainder <= fix_r;
                out_dz        <= fix_dz;
                out_ov        <= fix_ov;
            end
        end
    end

    // Saturating event counters, bumped on delivered DZ/OV results.
    always_ff @(posedge clk) begin
        if (rst) begin
            dz_count <= '0;
            ov_count <= '0;
        end else begin
            if (deliver && out_dz && (dz_count != CNT_MAX)) begin
                dz_count <= dz_count + CNT_W'(1);
            end
            if (deliver && out_ov && (ov_count != CNT_MAX)) begin
                ov_count <= ov_count + CNT_W'(1);
            end
        end
    end

endmodule
